// File: rtl/sc_backg_pkg.sv
// Shared state encodings, shift-select codes and default shift periods for the
// background lane controller.
package sc_backg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_RESTORE = 3'd5
  } backg_state_e;

  localparam logic [1:0] SHSEL_HOLD  = 2'b00;
  localparam logic [1:0] SHSEL_LEFT  = 2'b01;
  localparam logic [1:0] SHSEL_RIGHT = 2'b10;

  // Default level periods in 50 MHz clocks; each level halves the period.
  localparam int unsigned PERIOD_L0_DEF = 12500000;
  localparam int unsigned PERIOD_L1_DEF = 6250000;
  localparam int unsigned PERIOD_L2_DEF = 3125000;
  localparam int unsigned PERIOD_L3_DEF = 1562500;

endpackage

// File: rtl/sc_backg_period_counter.sv
// Shift-period counter: synchronous clear, count enable and a terminal-count
// flag raised when the count reaches period_i - 1.
module sc_backg_period_counter #(
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [COUNT_WIDTH-1:0] period_i,
  output logic                   tc_o
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // NOTE: count_d gets a default first so this block can never infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == (period_i - COUNT_WIDTH'(1)));

endmodule

// File: rtl/sc_backg_lane_ctrl.sv
// Background lane controller: sequences clear/load/load2 and periodic
// left/right shifts of the lane register, with level-selected shift period.
module sc_backg_lane_ctrl
  import sc_backg_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned PERIOD_L0   = PERIOD_L0_DEF,
  parameter int unsigned PERIOD_L1   = PERIOD_L1_DEF,
  parameter int unsigned PERIOD_L2   = PERIOD_L2_DEF,
  parameter int unsigned PERIOD_L3   = PERIOD_L3_DEF
) (
  input  logic       SC_RegBACKGTYPE_CLOCK_50,
  input  logic       SC_RegBACKGTYPE_RESET_InHigh,
  input  logic       start_InLow,
  input  logic       restore_InLow,
  input  logic       stop_InLow,
  input  logic       pause_InLow,
  input  logic [1:0] level_In,
  input  logic       direction_In,
  output logic       clear_OutLow,
  output logic       load_OutLow,
  output logic       load2_OutLow,
  output logic [1:0] shiftselection_Out,
  output logic       running_Out
);

  backg_state_e           state_q;
  backg_state_e           state_d;
  logic [COUNT_WIDTH-1:0] period_q;
  logic [COUNT_WIDTH-1:0] period_sel;
  logic                   cnt_tc;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   expire;
  logic                   clear_q;
  logic                   load_q;
  logic                   load2_q;
  logic [1:0]             shsel_q;
  logic                   running_q;

  always_comb begin
    case (level_In)
      2'd0:    period_sel = COUNT_WIDTH'(PERIOD_L0);
      2'd1:    period_sel = COUNT_WIDTH'(PERIOD_L1);
      2'd2:    period_sel = COUNT_WIDTH'(PERIOD_L2);
      default: period_sel = COUNT_WIDTH'(PERIOD_L3);
    endcase
  end

  assign expire = (state_q == ST_WAIT) && pause_InLow && cnt_tc;

  // Request priority: start > stop > restore > period expiry.
  always_comb begin
    state_d = state_q;
    if (!start_InLow) begin
      state_d = ST_CLEAR;
    end else if (!stop_InLow) begin
      state_d = ST_IDLE;
    end else if (!restore_InLow && (state_q == ST_WAIT || state_q == ST_SHIFT)) begin
      state_d = ST_RESTORE;
    end else begin
      case (state_q)
        ST_CLEAR:                      state_d = ST_LOAD;
        ST_LOAD, ST_SHIFT, ST_RESTORE: state_d = ST_WAIT;
        ST_WAIT:                       if (expire) state_d = ST_SHIFT;
        default:                       state_d = state_q;
      endcase
    end
  end

  // The SHIFT cycle counts as the first cycle of the next period, so pulses
  // repeat every period_q clocks in steady state.
  assign cnt_clr = (state_d != ST_WAIT && state_d != ST_SHIFT) || expire;
  assign cnt_en  = pause_InLow && (state_q == ST_WAIT || state_q == ST_SHIFT);

  sc_backg_period_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_period_counter (
    .clk_i    (SC_RegBACKGTYPE_CLOCK_50),
    .rst_i    (SC_RegBACKGTYPE_RESET_InHigh),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .period_i (period_q),
    .tc_o     (cnt_tc)
  );

  // Outputs are registered decodes of the state register, so they trail it by
  // one clock and reset clears them immediately.
  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      period_q  <= COUNT_WIDTH'(PERIOD_L0);
      clear_q   <= 1'b1;
      load_q    <= 1'b1;
      load2_q   <= 1'b1;
      shsel_q   <= SHSEL_HOLD;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD || state_q == ST_SHIFT) begin
        period_q <= period_sel;
      end
      clear_q   <= (state_q != ST_CLEAR);
      load_q    <= (state_q != ST_LOAD);
      load2_q   <= (state_q != ST_RESTORE);
      shsel_q   <= (state_q == ST_SHIFT) ? (direction_In ? SHSEL_RIGHT : SHSEL_LEFT)
                                         : SHSEL_HOLD;
      running_q <= (state_q == ST_WAIT) || (state_q == ST_SHIFT) || (state_q == ST_RESTORE);
    end
  end

  assign clear_OutLow       = clear_q;
  assign load_OutLow        = load_q;
  assign load2_OutLow       = load2_q;
  assign shiftselection_Out = shsel_q;
  assign running_Out        = running_q;

endmodule

// File: tb/tb_sc_backg_lane_ctrl.sv
// Scoreboard bench for sc_backg_lane_ctrl: directed requests push expected
// output pulses (kind + cycle); a negedge monitor pops and compares them.
module tb_sc_backg_lane_ctrl;

  typedef enum int {EV_CLEAR, EV_LOAD, EV_LOAD2, EV_SHL, EV_SHR, EV_MULTI} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   k;
  int   m;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_n = 1'b1;
  logic       restore_n = 1'b1;
  logic       stop_n = 1'b1;
  logic       pause_n = 1'b1;
  logic [1:0] level = 2'd0;
  logic       dir = 1'b0;
  logic       clear_o;
  logic       load_o;
  logic       load2_o;
  logic [1:0] shsel_o;
  logic       running_o;

  sc_backg_lane_ctrl #(
    .COUNT_WIDTH (8),
    .PERIOD_L0   (4),
    .PERIOD_L1   (3),
    .PERIOD_L2   (5),
    .PERIOD_L3   (2)
  ) dut (
    .SC_RegBACKGTYPE_CLOCK_50     (clk),
    .SC_RegBACKGTYPE_RESET_InHigh (rst),
    .start_InLow                  (start_n),
    .restore_InLow                (restore_n),
    .stop_InLow                   (stop_n),
    .pause_InLow                  (pause_n),
    .level_In                     (level),
    .direction_In                 (dir),
    .clear_OutLow                 (clear_o),
    .load_OutLow                  (load_o),
    .load2_OutLow                 (load2_o),
    .shiftselection_Out           (shsel_o),
    .running_Out                  (running_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {26'd0, clear_o, load_o, load2_o, shsel_o, running_o}, 32'b111000);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic expect_ev(input ev_e kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // One-cycle low pulse on the selected request inputs.
  task automatic pulse(input bit do_start, input bit do_stop, input bit do_restore);
    start_n   = !do_start;
    stop_n    = !do_stop;
    restore_n = !do_restore;
    tick(1);
    start_n   = 1'b1;
    stop_n    = 1'b1;
    restore_n = 1'b1;
  endtask

  // Monitor: classify any active output pulse and compare with the queue head.
  int   mon_act;
  ev_e  mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_act  = 0;
      mon_kind = EV_MULTI;
      if (!clear_o) begin mon_act++; mon_kind = EV_CLEAR; end
      if (!load_o)  begin mon_act++; mon_kind = EV_LOAD;  end
      if (!load2_o) begin mon_act++; mon_kind = EV_LOAD2; end
      if (shsel_o == 2'b01) begin mon_act++; mon_kind = EV_SHL; end
      if (shsel_o == 2'b10) begin mon_act++; mon_kind = EV_SHR; end
      if (shsel_o == 2'b11) begin mon_act++; mon_kind = EV_MULTI; end
      if (mon_act > 1) mon_kind = EV_MULTI;
      if (mon_act > 0) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pulse: got %s at cycle %0d, expected none", mon_kind.name(), cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.kind != mon_kind || mon_e.cyc != cyc) begin
            n_errors++;
            $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                     mon_kind.name(), cyc, mon_e.kind.name(), mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1 check_idle("reset_idle");
    tick(3);
    rst = 1'b0;
    tick(2);

    // Requests other than start are ignored in IDLE.
    pulse(0, 1, 1);
    restore_n = 1'b0;
    tick(4);
    restore_n = 1'b1;
    tick(2);
    check_idle("idle_ignore");

    // Left rotation at level 0 (period 4), then stop.
    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    for (int i = 0; i < 3; i++) expect_ev(EV_SHL, k + 8 + 4 * i);
    pulse(1, 0, 0);
    wait_until(k + 14);
    check("run_left", {31'd0, running_o}, 32'd1);
    wait_until(k + 17);
    pulse(0, 1, 0);
    wait_until(k + 19);
    check_idle("stop_left");
    tick(3);

    // Right rotation at level 1 (period 3).
    k = cyc;
    level = 2'd1;
    dir   = 1'b1;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    for (int i = 0; i < 3; i++) expect_ev(EV_SHR, k + 7 + 3 * i);
    pulse(1, 0, 0);
    wait_until(k + 11);
    check("run_right", {31'd0, running_o}, 32'd1);
    wait_until(k + 14);
    pulse(0, 1, 0);
    wait_until(k + 16);
    check_idle("stop_right");
    level = 2'd0;
    dir   = 1'b0;
    tick(3);

    // Pause for 10 clocks mid-WAIT delays the next shift by exactly 10.
    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    expect_ev(EV_SHL, k + 8);
    expect_ev(EV_SHL, k + 12);
    expect_ev(EV_SHL, k + 26);
    expect_ev(EV_SHL, k + 30);
    pulse(1, 0, 0);
    wait_until(k + 13);
    pause_n = 1'b0;
    wait_until(k + 23);
    pause_n = 1'b1;
    wait_until(k + 31);
    pulse(0, 1, 0);
    wait_until(k + 33);
    check_idle("stop_pause");
    tick(3);

    // Level 0 -> 3 mid-WAIT: current period stays 4, later periods are 2.
    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    expect_ev(EV_SHL, k + 8);
    for (int i = 0; i < 3; i++) expect_ev(EV_SHL, k + 10 + 2 * i);
    pulse(1, 0, 0);
    wait_until(k + 5);
    level = 2'd3;
    wait_until(k + 14);
    pulse(0, 1, 0);
    wait_until(k + 16);
    check_idle("stop_level");
    level = 2'd0;
    tick(3);

    // Restore from WAIT restarts the period after a load2 pulse.
    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    expect_ev(EV_SHL, k + 8);
    expect_ev(EV_SHL, k + 12);
    expect_ev(EV_LOAD2, k + 15);
    expect_ev(EV_SHL, k + 20);
    expect_ev(EV_SHL, k + 24);
    pulse(1, 0, 0);
    wait_until(k + 13);
    pulse(0, 0, 1);
    wait_until(k + 15);
    check("run_restore", {31'd0, running_o}, 32'd1);

    // Start and restore together: start wins, no load2.
    m = k + 25;
    expect_ev(EV_CLEAR, m + 2);
    expect_ev(EV_LOAD, m + 3);
    expect_ev(EV_SHL, m + 8);
    expect_ev(EV_SHL, m + 12);
    wait_until(m);
    pulse(1, 0, 1);
    // Stop and restore together: stop wins, no load2.
    wait_until(m + 13);
    pulse(0, 1, 1);
    wait_until(m + 16);
    check_idle("stop_over_restore");
    tick(3);

    // Reset during LOAD forces outputs inactive at once; stays IDLE after.
    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    pulse(1, 0, 0);
    wait_until(k + 2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_idle("reset_in_load");
    tick(2);
    rst = 1'b0;
    tick(10);
    check_idle("post_reset_idle");

    k = cyc;
    expect_ev(EV_CLEAR, k + 2);
    expect_ev(EV_LOAD, k + 3);
    pulse(1, 0, 0);
    wait_until(k + 5);
    pulse(0, 1, 0);
    tick(4);
    check_idle("final_idle");
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
